hazard_ctrl: RTL and testbench
==============================

HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL use the following ports, clock and reset first. All pipeline-facing outputs are combinational from the registered state and the current inputs.
- clk  in  1  sole clock; all state updates on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- rs1_id, rs2_id  in  5  source registers of the instruction in ID (rv32i_reg).
- use_rs1_id, use_rs2_id  in  1  ID instruction reads rs1/rs2.
- rd_ex  in  5  destination register of the instruction in EX.
- ex_is_load  in  1  EX control word opcode == op_load.
- branch_taken_ex  in  1  EX resolved a taken branch or jump.
- imem_read, imem_resp  in  1  instruction-memory request and response.
- dmem_read, dmem_write, dmem_resp  in  1  data-memory request and response.
- stall_all  out  1  freeze PC and every pipeline register.
- stall_front  out  1  freeze PC and IF/ID only.
- bubble_ex  out  1  load all-zero control word into ID/EX.
- flush_front  out  1  zero IF/ID instruction and ID/EX control word.
- stall_cnt, bubble_cnt, flush_cnt  out  32  performance counters.

Function
REQ-002 SHALL define imem_pend = imem_read & ~imem_resp & ~imem_done, and dmem_pend = (dmem_read | dmem_write) & ~dmem_resp & ~dmem_done.
REQ-003 SHALL drive stall_all = imem_pend | dmem_pend.
REQ-004 SHALL set sticky flag imem_done (respectively dmem_done) at the clock edge when stall_all=1 and the matching resp=1.
- This holds an early response while the other port is still pending.
REQ-005 SHALL clear both done flags at every edge where stall_all=0.
REQ-006 SHALL define load_use = ex_is_load & (rd_ex != 0) & ((use_rs1_id & rs1_id == rd_ex) | (use_rs2_id & rs2_id == rd_ex)).
REQ-007 SHALL implement FSM states RUN, WAIT and FLUSH_PEND:
- RUN->WAIT when stall_all=1 and branch_taken_ex=0.
- RUN/WAIT->FLUSH_PEND when stall_all=1 and branch_taken_ex=1.
- WAIT->RUN when stall_all=0.
- FLUSH_PEND->RUN when stall_all=0.
REQ-008 SHALL assert flush_front = ~stall_all & (branch_taken_ex | state==FLUSH_PEND).
- A branch resolved during a memory stall is therefore never lost.
REQ-009 SHALL assert bubble_ex and stall_front = ~stall_all & ~flush_front & load_use, for exactly the cycle of detection.
- After the bubble, ex_is_load=0, so no retrigger occurs.
REQ-010 SHALL give priority stall_all > flush_front > load_use bubble; a squashed ID instruction never causes a bubble.
REQ-011 SHALL hold stall_front=0 and bubble_ex=0 whenever stall_all=1.
REQ-012 SHALL update the counters as follows:
- stall_cnt increments on each cycle with stall_all=1.
- bubble_cnt increments on each cycle with bubble_ex=1.
- flush_cnt increments on each cycle with flush_front=1.
- All counters are 32-bit, modulo 2^32: 0xFFFFFFFF+1 -> 0.
REQ-013 SHALL treat a response arriving in the same cycle as its request as complete: no stall, no flag set.

Reset
REQ-014 SHALL, while rst_n=0, force state=RUN, imem_done=dmem_done=0 and all counters=0, independent of clk.
REQ-015 SHALL drive all 1-bit outputs to 0 when rst_n=0 and the memory request inputs are 0.
REQ-016 SHALL abandon any pending flush or done flag on reset assertion mid-stall, resuming in RUN after deassertion.

Structure
REQ-017 SHALL take rv32i_reg, rv32i_opcode and op_load from shared package rv32i_types.
REQ-018 SHALL add enum hazard_state_t {RUN, WAIT, FLUSH_PEND} to rv32i_types.
REQ-019 SHALL place the three counters in one reusable sub-module perf_counter (clk, rst_n, inc, 32-bit count), instantiated three times.

Verification
REQ-020 SHALL cover these directed scenarios:
- Load-use: ex_is_load=1, rd_ex=5, rs1_id=5, use_rs1_id=1 -> bubble_ex=stall_front=1 for one cycle; bubble_cnt=1.
- x0: same as load-use but rd_ex=0, rs1_id=0 -> no bubble, no stall.
- Split response: imem_read=dmem_read=1; imem_resp at cycle 1, dmem_resp at cycle 3 -> stall_all=1 for cycles 0-2, 0 at cycle 3; stall_cnt=3.
- Branch during stall: dmem_read pending, branch_taken_ex pulses at cycle 1, dmem_resp at cycle 4 -> flush_front=1 at cycle 4 only; flush_cnt=1.
- Flush beats load-use: branch_taken_ex=1 with load_use=1, no memory stall -> flush_front=1, bubble_ex=0.
- Reset mid-stall: rst_n low during FLUSH_PEND -> counters 0 and state RUN immediately; no flush after release.

Source files
------------

// File: rtl/rv32i_types.sv
// Shared RV32I type package.
// Provides the register-index type, the major opcode encoding (op_load is the
// one the hazard logic cares about) and the hazard controller's FSM states.
package rv32i_types;

  typedef logic [4:0] rv32i_reg;

  typedef enum logic [6:0] {
    op_lui   = 7'b0110111,
    op_auipc = 7'b0010111,
    op_jal   = 7'b1101111,
    op_jalr  = 7'b1100111,
    op_br    = 7'b1100011,
    op_load  = 7'b0000011,
    op_store = 7'b0100011,
    op_imm   = 7'b0010011,
    op_reg   = 7'b0110011,
    op_csr   = 7'b1110011
  } rv32i_opcode;

  // FLUSH_PEND remembers a taken branch seen while memory held the pipeline.
  typedef enum logic [1:0] {
    RUN        = 2'b00,
    WAIT       = 2'b01,
    FLUSH_PEND = 2'b10
  } hazard_state_t;

endpackage

// File: rtl/perf_counter.sv
// Free-running 32-bit event counter, wraps modulo 2^32.
// Ports: clk, rst_n (async active-low), inc (count this cycle), count.
module perf_counter (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        inc,
  output logic [31:0] count
);

  // Event accumulation; natural 32-bit overflow gives the wrap to zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= 32'd0;
    end else if (inc) begin
      count <= count + 32'd1;
    end else begin
      count <= count;
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller for a 5-stage RV32I core.
// Combines memory stalls (with sticky early-response capture), load-use
// bubbles and branch flushes, and counts each kind of event.
// Ports:
//   clk, rst_n                     clock, async active-low reset
//   rs1_id, rs2_id, use_rs1_id/2   ID-stage source operands
//   rd_ex, ex_is_load              EX-stage destination / load flag
//   branch_taken_ex                EX resolved a taken branch/jump
//   imem_read/resp, dmem_read/write/resp  memory handshakes
//   stall_all, stall_front, bubble_ex, flush_front  pipeline controls
//   stall_cnt, bubble_cnt, flush_cnt                 performance counters
module hazard_ctrl
  import rv32i_types::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  rv32i_reg    rs1_id,
  input  rv32i_reg    rs2_id,
  input  logic        use_rs1_id,
  input  logic        use_rs2_id,
  input  rv32i_reg    rd_ex,
  input  logic        ex_is_load,
  input  logic        branch_taken_ex,
  input  logic        imem_read,
  input  logic        imem_resp,
  input  logic        dmem_read,
  input  logic        dmem_write,
  input  logic        dmem_resp,
  output logic        stall_all,
  output logic        stall_front,
  output logic        bubble_ex,
  output logic        flush_front,
  output logic [31:0] stall_cnt,
  output logic [31:0] bubble_cnt,
  output logic [31:0] flush_cnt
);

  hazard_state_t state_r, state_next_s;
  logic imem_done_r, dmem_done_r;
  logic imem_pend_s, dmem_pend_s;
  logic stall_s, flush_s, load_use_s, bubble_s;

  // Memory stall: a port is pending until its response arrives, either now
  // or earlier during this same stall (captured in the done flags).
  always_comb begin
    imem_pend_s = imem_read & ~imem_resp & ~imem_done_r;
    dmem_pend_s = (dmem_read | dmem_write) & ~dmem_resp & ~dmem_done_r;
    stall_s     = imem_pend_s | dmem_pend_s;
  end

  // Load-use detection; x0 never carries a real dependency.
  always_comb begin
    load_use_s = ex_is_load & (rd_ex != 5'd0) &
                 ((use_rs1_id & (rs1_id == rd_ex)) |
                  (use_rs2_id & (rs2_id == rd_ex)));
  end

  // Priority: memory stall, then flush, then bubble (a squashed ID
  // instruction must not create a bubble).
  always_comb begin
    if (stall_s) begin
      flush_s  = 1'b0;
      bubble_s = 1'b0;
    end else begin
      flush_s  = branch_taken_ex | (state_r == FLUSH_PEND);
      bubble_s = ~flush_s & load_use_s;
    end
  end

  // Output drive; held low while in reset so the pipeline sees no control.
  always_comb begin
    if (!rst_n) begin
      stall_all   = 1'b0;
      flush_front = 1'b0;
      bubble_ex   = 1'b0;
      stall_front = 1'b0;
    end else begin
      stall_all   = stall_s;
      flush_front = flush_s;
      bubble_ex   = bubble_s;
      stall_front = bubble_s;
    end
  end

  // Sticky early-response flags, cleared as soon as the stall ends.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      imem_done_r <= 1'b0;
      dmem_done_r <= 1'b0;
    end else if (stall_s) begin
      imem_done_r <= imem_done_r | imem_resp;
      dmem_done_r <= dmem_done_r | dmem_resp;
    end else begin
      imem_done_r <= 1'b0;
      dmem_done_r <= 1'b0;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= RUN;
    end else begin
      state_r <= state_next_s;
    end
  end

  // FSM next state: a branch seen under stall parks in FLUSH_PEND until
  // the stall releases, when flush_front replays it.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      RUN, WAIT: begin
        if (stall_s && branch_taken_ex) begin
          state_next_s = FLUSH_PEND;
        end else if (stall_s) begin
          state_next_s = WAIT;
        end else begin
          state_next_s = RUN;
        end
      end
      FLUSH_PEND: begin
        if (stall_s) begin
          state_next_s = FLUSH_PEND;
        end else begin
          state_next_s = RUN;
        end
      end
      default: begin
        state_next_s = RUN;
      end
    endcase
  end

  perf_counter u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (stall_s),
    .count (stall_cnt)
  );

  perf_counter u_bubble_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (bubble_s),
    .count (bubble_cnt)
  );

  perf_counter u_flush_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (flush_s),
    .count (flush_cnt)
  );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: each stimulus cycle pushes the reference
// model's expected outputs; a monitor pops and compares on the falling edge.
module tb_hazard_ctrl;

  logic        clk;
  logic        rst_n;
  logic [4:0]  rs1_id, rs2_id, rd_ex;
  logic        use_rs1_id, use_rs2_id, ex_is_load, branch_taken_ex;
  logic        imem_read, imem_resp, dmem_read, dmem_write, dmem_resp;
  logic        stall_all, stall_front, bubble_ex, flush_front;
  logic [31:0] stall_cnt, bubble_cnt, flush_cnt;

  typedef struct {
    logic        stall;
    logic        front;
    logic        bubble;
    logic        flush;
    logic [31:0] scnt;
    logic [31:0] bcnt;
    logic [31:0] fcnt;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model state, phrased in terms of the protocol:
  // which responses already came back during the current stall, and
  // whether a taken branch is still owed a flush.
  bit          m_igot, m_dgot, m_owed;
  logic [31:0] m_scnt, m_bcnt, m_fcnt;

  hazard_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .rs1_id(rs1_id), .rs2_id(rs2_id),
    .use_rs1_id(use_rs1_id), .use_rs2_id(use_rs2_id),
    .rd_ex(rd_ex), .ex_is_load(ex_is_load),
    .branch_taken_ex(branch_taken_ex),
    .imem_read(imem_read), .imem_resp(imem_resp),
    .dmem_read(dmem_read), .dmem_write(dmem_write), .dmem_resp(dmem_resp),
    .stall_all(stall_all), .stall_front(stall_front),
    .bubble_ex(bubble_ex), .flush_front(flush_front),
    .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt), .flush_cnt(flush_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
    end
  endtask

  // One cycle: drive inputs away from the edge, predict, push, advance model.
  task automatic step(input bit rst, input bit ir, input bit irs, input bit dr,
                      input bit dw, input bit drs, input bit br, input bit ld,
                      input logic [4:0] rd, input logic [4:0] r1, input bit u1,
                      input logic [4:0] r2, input bit u2);
    exp_t e;
    bit iw, dwt, st, fl, lu, bu;
    @(posedge clk);
    #2;
    rst_n = rst; imem_read = ir; imem_resp = irs; dmem_read = dr;
    dmem_write = dw; dmem_resp = drs; branch_taken_ex = br; ex_is_load = ld;
    rd_ex = rd; rs1_id = r1; use_rs1_id = u1; rs2_id = r2; use_rs2_id = u2;
    if (!rst) begin
      m_igot = 1'b0; m_dgot = 1'b0; m_owed = 1'b0;
      m_scnt = 32'd0; m_bcnt = 32'd0; m_fcnt = 32'd0;
      e = '{1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0};
      exp_q.push_back(e);
    end else begin
      iw  = ir && !irs && !m_igot;
      dwt = (dr || dw) && !drs && !m_dgot;
      st  = iw || dwt;
      fl  = !st && (br || m_owed);
      lu  = ld && (rd != 5'd0) && ((u1 && r1 == rd) || (u2 && r2 == rd));
      bu  = !st && !fl && lu;
      e = '{st, bu, bu, fl, m_scnt, m_bcnt, m_fcnt};
      exp_q.push_back(e);
      if (st) begin
        m_igot = m_igot || irs;
        m_dgot = m_dgot || drs;
        m_owed = m_owed || br;
      end else begin
        m_igot = 1'b0; m_dgot = 1'b0; m_owed = 1'b0;
      end
      m_scnt = m_scnt + {31'd0, st};
      m_bcnt = m_bcnt + {31'd0, bu};
      m_fcnt = m_fcnt + {31'd0, fl};
    end
  endtask

  task automatic idle();
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0);
  endtask

  task automatic hold_reset();
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0);
  endtask

  // Monitor: compare whatever the DUT presents against the oldest prediction.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("stall_all",   {31'd0, stall_all},   {31'd0, e.stall});
        chk("stall_front", {31'd0, stall_front}, {31'd0, e.front});
        chk("bubble_ex",   {31'd0, bubble_ex},   {31'd0, e.bubble});
        chk("flush_front", {31'd0, flush_front}, {31'd0, e.flush});
        chk("stall_cnt",   stall_cnt,  e.scnt);
        chk("bubble_cnt",  bubble_cnt, e.bcnt);
        chk("flush_cnt",   flush_cnt,  e.fcnt);
      end
    end
  end

  initial begin
    int wait_cycles;
    rst_n = 1'b0;
    imem_read = 1'b0; imem_resp = 1'b0; dmem_read = 1'b0; dmem_write = 1'b0;
    dmem_resp = 1'b0; branch_taken_ex = 1'b0; ex_is_load = 1'b0;
    rd_ex = 5'd0; rs1_id = 5'd0; rs2_id = 5'd0; use_rs1_id = 1'b0; use_rs2_id = 1'b0;
    m_igot = 1'b0; m_dgot = 1'b0; m_owed = 1'b0;
    m_scnt = 32'd0; m_bcnt = 32'd0; m_fcnt = 32'd0;

    hold_reset();
    hold_reset();
    idle();

    // Load-use on rs1, then the bubbled cycle (EX no longer a load).
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd5, 5'd5, 1'b1, 5'd0, 1'b0);
    idle();
    // Load-use through rs2.
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd7, 5'd1, 1'b1, 5'd7, 1'b1);
    idle();
    // x0 destination never bubbles.
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd0, 5'd0, 1'b1, 5'd0, 1'b0);
    idle();

    // Split response: imem back at cycle 1, dmem at cycle 3.
    step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0);
    idle();

    // Same-cycle response: no stall.
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0);
    idle();

    // Branch during a data stall: flush only when the stall releases.
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0);
    idle();

    // Flush beats load-use.
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 5'd9, 5'd9, 1'b1, 5'd0, 1'b0);
    idle();

    // Reset mid-stall with a branch parked: everything abandoned.
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0);
    hold_reset();
    hold_reset();
    idle();
    idle();

    // Randomized traffic with small register indices to provoke matches.
    for (int i = 0; i < 400; i++) begin
      step(1'b1,
           ($urandom_range(0, 2) == 0), ($urandom_range(0, 2) == 0),
           ($urandom_range(0, 3) == 0), ($urandom_range(0, 5) == 0),
           ($urandom_range(0, 2) == 0), ($urandom_range(0, 4) == 0),
           ($urandom_range(0, 1) == 0),
           5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), ($urandom_range(0, 1) == 0),
           5'($urandom_range(0, 3)), ($urandom_range(0, 1) == 0));
      if (i == 200) begin
        hold_reset();
      end
    end
    idle();

    wait_cycles = 0;
    while (exp_q.size() > 0 && wait_cycles < 10) begin
      @(posedge clk);
      wait_cycles++;
    end
    @(posedge clk);
    if (exp_q.size() > 0) begin
      errors++;
      $display("FAIL drain: %0d predictions left, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
